// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes on request and result.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          request handshake
//   op                         00 MULU, 01 MULS, 10 DIVU, 11 DIVS
//   a, b                       operands (multiplicand/dividend, multiplier/divisor)
//   tag                        destination register index
//   out_valid/out_ready        result handshake
//   out_lo                     product low word or quotient
//   out_hi                     product high word or remainder
//   out_tag                    tag captured at accept
//   out_dbz                    divide-by-zero flag
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dbz
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    // m_q: multiplicand (mul) or divisor (div)
    // lo_q: multiplier shifting out (mul) or dividend shifting out (div)
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   mul_hi_nx;
    logic [WIDTH-1:0]   mul_lo_nx;
    logic [WIDTH-1:0]   div_hi_nx;
    logic [WIDTH-1:0]   div_lo_nx;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic               last;

    always_comb begin
        a_neg = op[0] & a[WIDTH-1];
        b_neg = op[0] & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;

        // Multiply step: conditional add, then shift {hi,lo} right.
        add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        mul_hi_nx = add_sum[WIDTH:1];
        mul_lo_nx = {add_sum[0], lo_q[WIDTH-1:1]};

        // Restoring divide step: borrow bit WIDTH set means no subtract.
        trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, m_q};
        if (!trial[WIDTH]) begin
            div_hi_nx = trial[WIDTH-1:0];
            div_lo_nx = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_hi_nx = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            div_lo_nx = {lo_q[WIDTH-2:0], 1'b0};
        end

        prod   = {mul_hi_nx, mul_lo_nx};
        prod_s = neg_lo ? -prod : prod;
        quo_s  = neg_lo ? -div_lo_nx : div_lo_nx;
        rem_s  = neg_hi ? -div_hi_nx : div_hi_nx;
        last   = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_lo    <= '0;
            out_hi    <= '0;
            out_tag   <= '0;
            out_dbz   <= 1'b0;
            count     <= '0;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        out_tag  <= tag;
                        is_div   <= op[1];
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= a_neg;
                        count    <= '0;
                        if (op[1] && (b == '0)) begin
                            out_lo    <= '1;
                            out_hi    <= a;
                            out_dbz   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            out_dbz <= 1'b0;
                            hi_q    <= '0;
                            lo_q    <= op[1] ? a_mag : b_mag;
                            m_q     <= op[1] ? b_mag : a_mag;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    hi_q  <= is_div ? div_hi_nx : mul_hi_nx;
                    lo_q  <= is_div ? div_lo_nx : mul_lo_nx;
                    if (last) begin
                        out_lo    <= is_div ? quo_s : prod_s[WIDTH-1:0];
                        out_hi    <= is_div ? rem_s : prod_s[2*WIDTH-1:WIDTH];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: 32-bit and 8-bit instances,
// latency, arithmetic, divide-by-zero, backpressure and mid-op reset.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, out_dbz;
    logic [1:0]  op;
    logic [31:0] a, b, out_lo, out_hi;
    logic [4:0]  tag, out_tag;

    logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8, out_dbz_8;
    logic [1:0]  op_8;
    logic [7:0]  a_8, b_8, out_lo_8, out_hi_8;
    logic [4:0]  tag_8, out_tag_8;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .tag(tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lo(out_lo), .out_hi(out_hi),
        .out_tag(out_tag), .out_dbz(out_dbz)
    );

    mul_div_unit #(.WIDTH(8), .TAG_W(5)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_8), .in_ready(in_ready_8),
        .op(op_8), .a(a_8), .b(b_8), .tag(tag_8),
        .out_valid(out_valid_8), .out_ready(out_ready_8),
        .out_lo(out_lo_8), .out_hi(out_hi_8),
        .out_tag(out_tag_8), .out_dbz(out_dbz_8)
    );

    task automatic check(input string nm, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, wait for result,
    // check it, then hand it off.  Latency counts edges after the
    // accept edge (0 means valid in the cycle right after accept).
    task automatic run(input bit w8, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] t, input int exp_lat,
                       input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                       input logic exp_dbz, input string nm);
        int lat;
        bit got;
        @(negedge clk);
        check({nm, "_in_ready"}, w8 ? in_ready_8 : in_ready, 1);
        if (w8) begin
            in_valid_8 = 1'b1; op_8 = o; a_8 = x[7:0]; b_8 = y[7:0]; tag_8 = t;
        end else begin
            in_valid = 1'b1; op = o; a = x; b = y; tag = t;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_valid_8 = 1'b0;
        a = ~x; b = ~y; tag = ~t;
        a_8 = ~x[7:0]; b_8 = ~y[7:0]; tag_8 = ~t;
        lat = 0;
        got = w8 ? out_valid_8 : out_valid;
        while (!got && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            got = w8 ? out_valid_8 : out_valid;
        end
        check({nm, "_lat"}, lat, exp_lat);
        check({nm, "_lo"}, w8 ? {24'h0, out_lo_8} : out_lo, exp_lo);
        check({nm, "_hi"}, w8 ? {24'h0, out_hi_8} : out_hi, exp_hi);
        check({nm, "_tag"}, w8 ? out_tag_8 : out_tag, t);
        check({nm, "_dbz"}, w8 ? out_dbz_8 : out_dbz, exp_dbz);
        out_ready = 1'b1; out_ready_8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0; out_ready_8 = 1'b0;
        check({nm, "_drop"}, w8 ? out_valid_8 : out_valid, 0);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        in_valid = 0; op = 0; a = 0; b = 0; tag = 0; out_ready = 0;
        in_valid_8 = 0; op_8 = 0; a_8 = 0; b_8 = 0; tag_8 = 0; out_ready_8 = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_lo", out_lo, 0);
        check("rst_out_hi", out_hi, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_dbz", out_dbz, 0);
        check("rst8_in_ready", in_ready_8, 1);
        check("rst8_out_valid", out_valid_8, 0);
        rst_n = 1'b1;

        run(0, 2'b00, 12, 8, 1, 32, 96, 0, 0, "mulu_12x8");
        run(0, 2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 2, 32,
            32'h8000_0000, 32'h0000_0000, 0, "muls_m1xmin");
        run(0, 2'b00, 32'hFFFF_FFFF, 32'h8000_0000, 3, 32,
            32'h8000_0000, 32'h7FFF_FFFF, 0, "mulu_maxxmin");
        run(0, 2'b11, 32'hFFFF_FFF9, 2, 4, 32,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, "divs_m7d2");
        run(0, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5, 32,
            32'h8000_0000, 0, 0, "divs_ovf");
        run(0, 2'b11, 7, 32'hFFFF_FFFE, 6, 32,
            32'hFFFF_FFFD, 1, 0, "divs_7dm2");
        run(0, 2'b10, 100, 7, 7, 32, 14, 2, 0, "divu_100d7");
        run(0, 2'b10, 100, 0, 8, 0, 32'hFFFF_FFFF, 100, 1, "divu_dbz");

        // Backpressure: result held while a new request waits.
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; a = 6; b = 7; tag = 3;
        @(posedge clk);
        #1;
        a = 2; b = 3; tag = 4;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("bp_lat", lat, 32);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_lo", out_lo, 42);
            check("bp_tag", out_tag, 3);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_drop", out_valid, 0);
        check("bp_ready_back", in_ready, 1);
        @(posedge clk);
        #1;
        check("bp_accept2", in_ready, 0);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("bp2_lat", lat, 32);
        check("bp2_lo", out_lo, 6);
        check("bp2_tag", out_tag, 4);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; a = 32'hFFFF; b = 32'hFFFF; tag = 9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_lo", out_lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 2'b00, 3, 5, 10, 32, 15, 0, 0, "mulu_3x5");

        run(1, 2'b00, 255, 255, 11, 8, 8'h01, 8'hFE, 0, "mulu8_ff");
        run(1, 2'b11, 8'h9C, 7, 12, 8, 8'hF2, 8'hFE, 0, "divs8_m100d7");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide execution unit for the processor datapath.
- Replaces the single-cycle MUL path that writes {SGPR, GPR[rdst]}.
- Supports unsigned/signed multiply and unsigned/signed divide with a valid/ready handshake on both sides.
- Returns a double-width product (hi word → SGPR, lo word → GPR[rdst]), or quotient/remainder, tagged with the destination register index.

Parameters:
- WIDTH, 32, operand width in bits (≥4).
- TAG_W, 5, width of destination-register tag (log2 of GPR count).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept a request
- op  input  2  00 MULU, 01 MULS, 10 DIVU, 11 DIVS
- a  input  WIDTH  operand 1 (multiplicand / dividend)
- b  input  WIDTH  operand 2 (multiplier / divisor)
- tag  input  TAG_W  destination register index (rdst)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_lo  output  WIDTH  product low word, or quotient
- out_hi  output  WIDTH  product high word (SGPR), or remainder
- out_tag  output  TAG_W  tag captured at accept
- out_dbz  output  1  divide-by-zero flag for this result

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0.
  - out_lo=0, out_hi=0, out_tag=0, out_dbz=0, iteration counter=0.
  - Takes effect mid-operation; the in-flight op is discarded with no output.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready edge, capture op, tag, and operand magnitudes (abs value for signed ops; record result signs).
  - Go to CALC with count=0.
  - Exception: a DIV op with b==0 goes directly to DONE.
- CALC:
  - in_ready=0.
  - One iteration per edge:
    - Multiply: shift-add, 1 multiplier bit per cycle.
    - Divide: restoring, 1 quotient bit per cycle.
  - On the edge where count==WIDTH-1, apply sign correction, register outputs, go to DONE.
  - Latency: out_valid rises exactly WIDTH cycles after the accept edge.
- DONE:
  - out_valid=1; outputs held stable until out_valid&out_ready.
  - On that edge: out_valid=0, go to IDLE.
  - in_ready stays 0 in DONE; the next accept happens at the earliest one cycle after the handoff.
- Arithmetic:
  - MULU: {out_hi,out_lo} = a*b, unsigned, 2*WIDTH bits, exact.
  - MULS: two's-complement 2*WIDTH product. The product is negated if the operand signs differ.
  - DIVU: out_lo = a/b, out_hi = a%b.
  - DIVS:
    - Quotient truncates toward zero; remainder takes the dividend's sign.
    - Overflow case a=MIN, b=-1 gives out_lo=MIN, out_hi=0, out_dbz=0.
- Divide by zero:
  - out_lo = all ones, out_hi = a (unmodified).
  - out_dbz=1; latency 1 cycle (IDLE→DONE).
- out_dbz is 0 for all multiply ops.
- Requests with in_valid=1 while in_ready=0 are ignored; the requester must hold them.
- Operand and tag inputs are sampled only at the accept edge; later changes have no effect.
- out_ready asserted outside DONE has no effect.

Test Plan:
- MULU a=12, b=8, tag=1, out_ready=1 → out_valid exactly 32 cycles after accept; out_lo=96, out_hi=0, out_tag=1.
- MULS a=0xFFFFFFFF (-1), b=0x80000000 → out_hi=0x00000000, out_lo=0x80000000. Then MULU with the same operands → out_hi=0x7FFFFFFF, out_lo=0x80000000.
- DIVS a=-7, b=2 → out_lo=0xFFFFFFFD (-3), out_hi=0xFFFFFFFF (-1). Then DIVS a=0x80000000, b=-1 → out_lo=0x80000000, out_hi=0, out_dbz=0.
- DIVU a=100, b=0 → out_valid one cycle after accept; out_lo=0xFFFFFFFF, out_hi=100, out_dbz=1.
- Backpressure case:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid; keep in_valid=1 with new operands throughout.
  - Required: outputs stable, in_ready=0 and no second accept during the hold.
  - Then pulse out_ready → next request accepted on the following cycle.
- Reset case:
  - Stimulus: assert rst_n=0 at cycle 15 of a MULU; release; then issue MULU 3*5.
  - Required: out_valid=0 and in_ready=1 immediately on reset; no stale result; the new MULU yields out_lo=15 after 32 cycles.
  - Repeat with WIDTH=8: 255*255 → out_hi=0xFE, out_lo=0x01, latency 8.
